// File: rtl/add_sub_norm_pipe_pkg.sv
// Shared constants and helpers for the add/sub post-normalization stage.
package add_sub_norm_pipe_pkg;

  localparam int unsigned SWR_DEF = 26;
  localparam int unsigned EWR_DEF = 8;

  // Datapath selected in S1, consumed by S2.
  typedef enum logic [1:0] {
    PATH_CARRY = 2'd0,
    PATH_NORM  = 2'd1,
    PATH_ZERO  = 2'd2
  } path_e;

  // Count width must also represent "all zeros" (== SWR).
  function automatic int unsigned lzw_of(input int unsigned swr);
    return $clog2(swr + 1);
  endfunction

endpackage

// File: rtl/add_sub_norm_pipe_lzd_count.sv
// Leading-zero counter: MSB-first priority encoder, returns SWR for an all-zero word.
module add_sub_norm_pipe_lzd_count
  import add_sub_norm_pipe_pkg::*;
#(
  parameter int unsigned SWR = SWR_DEF,
  parameter int unsigned LZW = lzw_of(SWR)
) (
  input  logic [SWR-1:0] i_sum,
  output logic [LZW-1:0] o_lz
);

  // Scan upward so the highest set bit makes the last (winning) assignment.
  always_comb begin
    o_lz = LZW'(SWR);
    for (int i = 0; i < SWR; i++) begin
      if (i_sum[i]) o_lz = LZW'(SWR - 1 - i);
    end
  end

endmodule

// File: rtl/add_sub_norm_pipe.sv
// Two-stage post-addition normalizer: S1 captures operands plus leading-zero count,
// S2 shifts, adjusts the exponent and raises the exception flags.
module add_sub_norm_pipe
  import add_sub_norm_pipe_pkg::*;
#(
  parameter int unsigned SWR = SWR_DEF,
  parameter int unsigned EWR = EWR_DEF,
  parameter int unsigned LZW = lzw_of(SWR)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [SWR-1:0] Sum_i,
  input  logic           C_i,
  input  logic           Sub_i,
  input  logic [EWR-1:0] Exp_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [SWR-1:0] Sgf_o,
  output logic [EWR-1:0] Exp_o,
  output logic [LZW-1:0] LZ_o,
  output logic           Zero_o,
  output logic           Underflow_o,
  output logic           Overflow_o
);

  logic [LZW-1:0] w_lz;
  path_e          w_path;
  logic           w_s2_load;

  logic           r_s1_valid;
  logic [SWR-1:0] r_s1_sum;
  logic [EWR-1:0] r_s1_exp;
  logic [LZW-1:0] r_s1_lz;
  path_e          r_s1_path;

  logic           r_s2_valid;
  logic [SWR-1:0] r_s2_sgf;
  logic [EWR-1:0] r_s2_exp;
  logic [LZW-1:0] r_s2_lz;
  logic           r_s2_zero;
  logic           r_s2_uf;
  logic           r_s2_of;

  logic [EWR:0]   w_exp_inc;
  logic [EWR:0]   w_exp_dec;
  logic           w_borrow;
  logic [LZW-1:0] w_shamt;
  logic [SWR-1:0] w_shifted;
  logic [SWR-1:0] w_sgf;
  logic [EWR-1:0] w_exp;
  logic [LZW-1:0] w_lz_out;
  logic           w_zero;
  logic           w_uf;
  logic           w_of;

  add_sub_norm_pipe_lzd_count #(
    .SWR (SWR),
    .LZW (LZW)
  ) u_lzd (
    .i_sum (Sum_i),
    .o_lz  (w_lz)
  );

  // S2 accepts whenever its slot is empty or being drained; S1 advances with it.
  assign w_s2_load = !r_s2_valid || ready_i;
  assign ready_o   = !r_s1_valid || w_s2_load;

  // Path select: carry only matters for effective addition.
  always_comb begin
    w_path = PATH_NORM;
    if (C_i && !Sub_i)     w_path = PATH_CARRY;
    else if (Sum_i == '0)  w_path = PATH_ZERO;
  end

  // S1 register: operands, leading-zero count and path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_exp   <= '0;
      r_s1_lz    <= '0;
      r_s1_path  <= PATH_CARRY;
    end else begin
      if (ready_o) r_s1_valid <= valid_i;
      if (valid_i && ready_o) begin
        r_s1_sum  <= Sum_i;
        r_s1_exp  <= Exp_i;
        r_s1_lz   <= w_lz;
        r_s1_path <= w_path;
      end
    end
  end

  // S2 datapath: exponent adjust (one extra bit for carry/borrow) and barrel shift.
  always_comb begin
    w_exp_inc = {1'b0, r_s1_exp} + (EWR+1)'(1);
    w_exp_dec = {1'b0, r_s1_exp} - (EWR+1)'(r_s1_lz);
    w_borrow  = w_exp_dec[EWR];
    // On borrow the exponent is smaller than lz (< SWR), so it fits in LZW bits.
    w_shamt   = w_borrow ? r_s1_exp[LZW-1:0] : r_s1_lz;
    w_shifted = r_s1_sum;
    for (int k = 0; k < LZW; k++) begin
      if (w_shamt[k]) w_shifted = w_shifted << (1 << k);
    end

    w_sgf    = '0;
    w_exp    = '0;
    w_lz_out = '0;
    w_zero   = 1'b0;
    w_uf     = 1'b0;
    w_of     = 1'b0;
    unique case (r_s1_path)
      PATH_CARRY: begin
        if (w_exp_inc >= {1'b0, {EWR{1'b1}}}) begin
          w_of  = 1'b1;
          w_exp = '1;
        end else begin
          w_sgf = {1'b1, r_s1_sum[SWR-1:2], |r_s1_sum[1:0]};
          w_exp = w_exp_inc[EWR-1:0];
        end
      end
      PATH_ZERO: begin
        w_zero   = 1'b1;
        w_lz_out = LZW'(SWR);
      end
      PATH_NORM: begin
        w_sgf    = w_shifted;
        w_lz_out = w_shamt;
        if (w_borrow) w_uf  = 1'b1;
        else          w_exp = w_exp_dec[EWR-1:0];
      end
      default: ;
    endcase
  end

  // S2 register: holds the result stable while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sgf   <= '0;
      r_s2_exp   <= '0;
      r_s2_lz    <= '0;
      r_s2_zero  <= 1'b0;
      r_s2_uf    <= 1'b0;
      r_s2_of    <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sgf  <= w_sgf;
        r_s2_exp  <= w_exp;
        r_s2_lz   <= w_lz_out;
        r_s2_zero <= w_zero;
        r_s2_uf   <= w_uf;
        r_s2_of   <= w_of;
      end
    end
  end

  assign valid_o     = r_s2_valid;
  assign Sgf_o       = r_s2_sgf;
  assign Exp_o       = r_s2_exp;
  assign LZ_o        = r_s2_lz;
  assign Zero_o      = r_s2_zero;
  assign Underflow_o = r_s2_uf;
  assign Overflow_o  = r_s2_of;

endmodule

// File: tb/tb_add_sub_norm_pipe.sv
// Directed bench for add_sub_norm_pipe with hand-computed expected results.
module tb_add_sub_norm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [25:0] Sum_i = '0;
  logic        C_i = 1'b0;
  logic        Sub_i = 1'b0;
  logic [7:0]  Exp_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [25:0] Sgf_o;
  logic [7:0]  Exp_o;
  logic [4:0]  LZ_o;
  logic        Zero_o;
  logic        Underflow_o;
  logic        Overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] bp_sgf [4] = '{26'h2000000, 26'h2000002, 26'h2000004, 26'h2000006};
  logic [7:0]  bp_exp [4] = '{8'd19, 8'd20, 8'd21, 8'd22};

  always #5 clk = ~clk;

  add_sub_norm_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .Sum_i       (Sum_i),
    .C_i         (C_i),
    .Sub_i       (Sub_i),
    .Exp_i       (Exp_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .Sgf_o       (Sgf_o),
    .Exp_o       (Exp_o),
    .LZ_o        (LZ_o),
    .Zero_o      (Zero_o),
    .Underflow_o (Underflow_o),
    .Overflow_o  (Overflow_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Called just after a posedge with an empty pipe and ready_i=1.
  // Flags are packed {Zero, Underflow, Overflow}.
  task automatic run_beat(input string tag, input logic [25:0] sum, input logic c,
                          input logic sub, input logic [7:0] e_in,
                          input logic [25:0] x_sgf, input logic [7:0] x_exp,
                          input logic [4:0] x_lz, input logic [2:0] x_flags);
    Sum_i = sum; C_i = c; Sub_i = sub; Exp_i = e_in; valid_i = 1'b1;
    check_eq({tag, "_rdy"}, 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check_eq({tag, "_early"}, 32'(valid_o), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"}, 32'(valid_o), 32'd1);
    check_eq({tag, "_sgf"}, 32'(Sgf_o), 32'(x_sgf));
    check_eq({tag, "_exp"}, 32'(Exp_o), 32'(x_exp));
    check_eq({tag, "_lz"},  32'(LZ_o),  32'(x_lz));
    check_eq({tag, "_flg"}, 32'({Zero_o, Underflow_o, Overflow_o}), 32'(x_flags));
    @(posedge clk); #1;
    check_eq({tag, "_drain"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int in_idx;
    int out_idx;

    // Reset state
    #1;
    check_eq("rst_vld", 32'(valid_o), 32'd0);
    check_eq("rst_rdy", 32'(ready_o), 32'd1);
    check_eq("rst_data", 32'({Sgf_o, Exp_o == 8'd0, LZ_o == 5'd0}), 32'({26'd0, 1'b1, 1'b1}));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    run_beat("norm",   26'h0800000, 1'b0, 1'b1, 8'd127, 26'h2000000, 8'd125, 5'd2,  3'b000);
    run_beat("carry",  26'h0000003, 1'b1, 1'b0, 8'd10,  26'h2000001, 8'd11,  5'd0,  3'b000);
    run_beat("ovf",    26'h0000003, 1'b1, 1'b0, 8'hFE,  26'h0000000, 8'hFF,  5'd0,  3'b001);
    run_beat("zero",   26'h0000000, 1'b0, 1'b1, 8'd50,  26'h0000000, 8'd0,   5'd26, 3'b100);
    run_beat("uflow",  26'h0000100, 1'b0, 1'b1, 8'd5,   26'h0002000, 8'd0,   5'd5,  3'b010);
    run_beat("lz_eq",  26'h0000100, 1'b0, 1'b1, 8'd17,  26'h2000000, 8'd0,   5'd17, 3'b000);
    run_beat("sub_c",  26'h2000000, 1'b1, 1'b1, 8'd3,   26'h2000000, 8'd3,   5'd0,  3'b000);

    // Backpressure: four beats, ready_i low for three stalled cycles
    in_idx = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 30 && out_idx < 4; cyc++) begin
      ready_i = (cyc >= 5);
      valid_i = (in_idx < 4);
      Sum_i   = 26'h1000000 + 26'(in_idx);
      Exp_i   = 8'(20 + in_idx);
      Sub_i   = 1'b1;
      C_i     = 1'b0;
      @(negedge clk);
      if (cyc >= 2 && cyc <= 4) begin
        check_eq("bp_rdy_low", 32'(ready_o), 32'd0);
        check_eq("bp_hold_vld", 32'(valid_o), 32'd1);
        check_eq("bp_hold_sgf", 32'(Sgf_o), 32'(bp_sgf[0]));
      end
      if (valid_o && ready_i) begin
        check_eq("bp_sgf", 32'(Sgf_o), 32'(bp_sgf[out_idx]));
        check_eq("bp_exp", 32'(Exp_o), 32'(bp_exp[out_idx]));
        check_eq("bp_lz",  32'(LZ_o),  32'd1);
        out_idx++;
      end
      if (valid_i && ready_o) in_idx++;
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    check_eq("bp_count", 32'(out_idx), 32'd4);
    check_eq("bp_in_count", 32'(in_idx), 32'd4);
    @(posedge clk); #1;

    // Reset mid-operation with both stages full
    ready_i = 1'b0;
    Sum_i = 26'h0000003; C_i = 1'b1; Sub_i = 1'b0; Exp_i = 8'd10; valid_i = 1'b1;
    @(posedge clk); #1;
    Sum_i = 26'h0800000; C_i = 1'b0; Sub_i = 1'b1; Exp_i = 8'd127;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check_eq("mid_full_vld", 32'(valid_o), 32'd1);
    check_eq("mid_full_rdy", 32'(ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_vld", 32'(valid_o), 32'd0);
    check_eq("mid_rst_sgf", 32'(Sgf_o), 32'd0);
    check_eq("mid_rst_exp", 32'(Exp_o), 32'd0);
    check_eq("mid_rst_lz",  32'(LZ_o),  32'd0);
    check_eq("mid_rst_flg", 32'({Zero_o, Underflow_o, Overflow_o}), 32'd0);
    check_eq("mid_rst_rdy", 32'(ready_o), 32'd1);
    #3;
    rst = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_vld", 32'(valid_o), 32'd0);
    run_beat("post_rst", 26'h0800000, 1'b0, 1'b1, 8'd127, 26'h2000000, 8'd125, 5'd2, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_sub_norm_pipe.md
Name: add_sub_norm_pipe

Overview:
- Post-addition normalization stage of the FPU add/subtract datapath; sits directly downstream of the ripple significand adder.
- Consumes the raw significand sum, adder carry-out, tentative exponent and effective-operation flag.
- Produces a normalized significand, adjusted exponent, leading-zero count and exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- SWR, 26, significand word width (hidden bit + fraction + guard bits).
- EWR, 8, exponent width.
- LZW, 5, leading-zero count width; must satisfy 2^LZW > SWR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept a beat.
- Sum_i  in  SWR  raw significand sum from the adder.
- C_i  in  1  adder carry-out.
- Sub_i  in  1  effective subtraction (1) or addition (0).
- Exp_i  in  EWR  tentative result exponent (larger operand exponent).
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the beat.
- Sgf_o  out  SWR  normalized significand.
- Exp_o  out  EWR  adjusted exponent.
- LZ_o  out  LZW  leading-zero count applied (0 on the carry path).
- Zero_o  out  1  result significand is zero.
- Underflow_o  out  1  normalization shift clipped by the exponent.
- Overflow_o  out  1  exponent saturated to all-ones.

Behaviour:
- Reset: all output registers and internal valid bits are cleared while rst=1, immediately and independent of clk. After reset, valid_o=0, all data/flag outputs=0 and ready_o=1. Reset mid-operation discards in-flight beats.
- Pipeline:
  - S1 registers the inputs together with lz = leading zeros of Sum_i (MSB first; 26 when Sum_i==0) and the path select.
  - S2 registers the shifted result and the flags.
  - Latency is 2 cycles from an accepted beat to valid_o. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers in when valid_i && ready_o; a beat transfers out when valid_o && ready_i.
  - S2 loads when !valid_o || ready_i. S1 advances when S2 loads.
  - ready_o = !s1_valid || s1_advance, so the pipe is fully registered with no bubbles.
  - While stalled (valid_o && !ready_i), outputs hold stable.
  - Data order is preserved and no beat is lost or duplicated.
- Carry path (C_i=1 && Sub_i=0):
  - Sgf_o = {1'b1, Sum_i[SWR-1:1]}, with Sgf_o[0] = Sum_i[1] | Sum_i[0] (sticky).
  - Exp_o = Exp_i + 1 and LZ_o = 0.
  - If Exp_i+1 == all-ones: Overflow_o=1, Exp_o=all-ones, Sgf_o=0.
- Normalize path (otherwise; C_i ignored when Sub_i=1):
  - If Sum_i==0: Zero_o=1, Exp_o=0, Sgf_o=0, LZ_o=SWR.
  - Else if lz <= Exp_i: Sgf_o = Sum_i << lz, Exp_o = Exp_i - lz, LZ_o = lz.
  - Else: Underflow_o=1, Sgf_o = Sum_i << Exp_i, Exp_o=0, LZ_o = Exp_i[LZW-1:0].
- Flag exclusivity: at most one of Zero_o, Underflow_o and Overflow_o is set per beat.
- Simultaneous events: an input accept and an output drain in the same cycle are both honoured.
- Arithmetic widths: exponent arithmetic is EWR+1 bits internally to detect borrow and carry. The shift is a log-depth barrel shifter in S2.

Decomposition:
- Shared package: LZW derivation function (clog2(SWR+1)), EWR/SWR defaults, and the path-select encoding constants (PATH_CARRY, PATH_NORM, PATH_ZERO).
- One sub-module: lzd_count — combinational priority encoder, SWR in, LZW out, instantiated in front of S1.

Test Plan:
- Sum_i=26'h0800000, C_i=0, Sub_i=1, Exp_i=127 → 2 cycles later: Sgf_o=26'h2000000, Exp_o=125, LZ_o=2, all flags 0.
- Sum_i=26'h0000003, C_i=1, Sub_i=0, Exp_i=10 → Sgf_o=26'h2000001, Exp_o=11, LZ_o=0. Repeat with Exp_i=8'hFE → Overflow_o=1, Exp_o=8'hFF, Sgf_o=0.
- Sum_i=0, Sub_i=1, Exp_i=50 → Zero_o=1, Exp_o=0, Sgf_o=0, LZ_o=26.
- Sum_i=26'h0000100 (lz=17), Exp_i=5 → Underflow_o=1, Sgf_o=26'h0002000, Exp_o=0, LZ_o=5.
- Backpressure: four back-to-back beats with ready_i held 0 for 3 cycles → ready_o falls after two beats are buffered, outputs hold stable, and all four emerge in order with none lost.
- Reset mid-operation: assert rst asynchronously with both stages valid → valid_o and all outputs go to 0 before the next clk edge. After release, ready_o=1 and the first new beat appears 2 cycles after acceptance.
